forward_hazard_unit: RTL and testbench

- Decode-side control block directly upstream of the execute-stage operand forwarding muxes.
- Tracks the destination registers of in-flight instructions in a shadow EX/MEM/WB slot pipeline.
- Drives registered forwardSelect1/forwardSelect2 into the execute stage in step with the ID/EX pipeline register.
- Detects load-use hazards and branch flushes, issues stall/bubble controls, and keeps saturating performance counters.

---
 rtl/forward_pkg.sv | 35 +++
 rtl/sat_counter.sv | 16 +
 rtl/forward_hazard_unit.sv | 84 ++++++++
 tb/tb_forward_hazard_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/forward_pkg.sv
// Shared types for the decode-side forwarding/hazard unit: slot records,
// forward-select encoding and the source-match rule.
package forward_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EX_MEM  = 2'b01,
    FWD_MEM_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regWrite;
    logic                  memRead;
  } slot_t;

  localparam slot_t BUBBLE_SLOT = '{valid: 1'b0, rd: '0, regWrite: 1'b0, memRead: 1'b0};

  // x0 is hardwired, so a producer of x0 never matches a consumer.
  function automatic logic slot_match(slot_t s, logic [REG_ADDR_W-1:0] src, logic uses);
    return s.valid && s.regWrite && (s.rd == src) && (s.rd != '0) && uses;
  endfunction

  // Youngest producer wins; WB-distance producers go through the write-first regfile.
  function automatic fwd_sel_t pick_fwd(slot_t ex, slot_t mem, logic [REG_ADDR_W-1:0] src,
                                        logic uses);
    if (slot_match(ex, src, uses))       return FWD_EX_MEM;
    else if (slot_match(mem, src, uses)) return FWD_MEM_WB;
    else                                 return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-high reset; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Decode-side shadow of EX/MEM/WB destinations: registered forward selects for EX,
// combinational load-use stall / branch flush controls, and event counters.
module forward_hazard_unit
  import forward_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      idValid,
  input  logic [REG_ADDR_WIDTH-1:0] idRs1,
  input  logic [REG_ADDR_WIDTH-1:0] idRs2,
  input  logic                      idUsesRs1,
  input  logic                      idUsesRs2,
  input  logic [REG_ADDR_WIDTH-1:0] idRd,
  input  logic                      idRegWrite,
  input  logic                      idMemRead,
  input  logic                      exBranchTaken,
  output logic [1:0]                forwardSelect1,
  output logic [1:0]                forwardSelect2,
  output logic                      pcWrite,
  output logic                      ifIdWrite,
  output logic                      idExBubble,
  output logic                      ifIdFlush,
  output logic [COUNT_WIDTH-1:0]    stallCount,
  output logic [COUNT_WIDTH-1:0]    flushCount
);

  slot_t    ex_slot, mem_slot, wb_slot;
  fwd_sel_t fsel1, fsel2;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic     ex_hit1, ex_hit2, load_use, flush, issue;

  assign rs1 = REG_ADDR_W'(idRs1);
  assign rs2 = REG_ADDR_W'(idRs2);
  assign rd  = REG_ADDR_W'(idRd);

  assign ex_hit1  = slot_match(ex_slot, rs1, idUsesRs1);
  assign ex_hit2  = slot_match(ex_slot, rs2, idUsesRs2);
  assign flush    = exBranchTaken;
  // A taken branch squashes the consumer anyway, so it masks the stall.
  assign load_use = idValid && ex_slot.memRead && (ex_hit1 || ex_hit2) && !exBranchTaken;
  assign issue    = idValid && !load_use && !flush;

  assign pcWrite    = !load_use;
  assign ifIdWrite  = !load_use;
  assign idExBubble = load_use || flush;
  assign ifIdFlush  = flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot  <= BUBBLE_SLOT;
      mem_slot <= BUBBLE_SLOT;
      wb_slot  <= BUBBLE_SLOT;
      fsel1    <= FWD_REGFILE;
      fsel2    <= FWD_REGFILE;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (issue) begin
        ex_slot <= '{valid: 1'b1, rd: rd, regWrite: idRegWrite, memRead: idMemRead};
        fsel1   <= pick_fwd(ex_slot, mem_slot, rs1, idUsesRs1);
        fsel2   <= pick_fwd(ex_slot, mem_slot, rs2, idUsesRs2);
      end else begin
        ex_slot <= BUBBLE_SLOT;
        fsel1   <= FWD_REGFILE;
        fsel2   <= FWD_REGFILE;
      end
    end
  end

  assign forwardSelect1 = fsel1;
  assign forwardSelect2 = fsel2;

  sat_counter #(.W(COUNT_WIDTH)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(load_use), .count(stallCount)
  );

  sat_counter #(.W(COUNT_WIDTH)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush), .count(flushCount)
  );

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding distances, load-use stall,
// x0/unused sources, flush priority, counter saturation and async reset.
module tb_forward_hazard_unit;

  // Narrow counters keep the saturation run short.
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          idValid, idUsesRs1, idUsesRs2, idRegWrite, idMemRead, exBranchTaken;
  logic [4:0]    idRs1, idRs2, idRd;
  logic [1:0]    forwardSelect1, forwardSelect2;
  logic          pcWrite, ifIdWrite, idExBubble, ifIdFlush;
  logic [CW-1:0] stallCount, flushCount;

  int checks   = 0;
  int failures = 0;

  forward_hazard_unit #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idRd(idRd), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
    .exBranchTaken(exBranchTaken),
    .forwardSelect1(forwardSelect1), .forwardSelect2(forwardSelect2),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExBubble(idExBubble), .ifIdFlush(ifIdFlush),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] d,
                       input logic rw, input logic mr, input logic br);
    idValid = v; idRs1 = r1; idUsesRs1 = u1; idRs2 = r2; idUsesRs2 = u2;
    idRd = d; idRegWrite = rw; idMemRead = mr; exBranchTaken = br;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    #12;
    chk("rst_fs1", 32'(forwardSelect1), 32'h0);
    chk("rst_fs2", 32'(forwardSelect2), 32'h0);
    chk("rst_pcw", 32'(pcWrite), 32'h1);
    chk("rst_ifidw", 32'(ifIdWrite), 32'h1);
    chk("rst_bubble", 32'(idExBubble), 32'h0);
    chk("rst_flush", 32'(ifIdFlush), 32'h0);
    chk("rst_stallcnt", 32'(stallCount), 32'h0);
    chk("rst_flushcnt", 32'(flushCount), 32'h0);
    @(negedge clk); reset = 1'b0;
    step();

    // ALU back-to-back: add x5 ; sub x?, x5, x6
    drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); step();
    drive(1, 5'd5, 1, 5'd6, 1, 5'd10, 1, 0, 0);
    chk("b2b_nostall", 32'(pcWrite), 32'h1);
    step();
    chk("b2b_fs1", 32'(forwardSelect1), 32'h1);
    chk("b2b_fs2", 32'(forwardSelect2), 32'h0);

    // Distance 2: add x7 ; nop ; or rs2=7
    drive(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0); step();
    nop(); step();
    drive(1, 5'd1, 1, 5'd7, 1, 5'd11, 1, 0, 0); step();
    chk("d2_fs2", 32'(forwardSelect2), 32'h2);
    chk("d2_fs1", 32'(forwardSelect1), 32'h0);

    // Distance 3: producer sits in WB, regfile bypass handles it
    drive(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0); step();
    nop(); step();
    nop(); step();
    drive(1, 5'd1, 1, 5'd7, 1, 5'd11, 1, 0, 0); step();
    chk("d3_fs2", 32'(forwardSelect2), 32'h0);

    // Load-use: lw x3 ; add rs1=3
    drive(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); step();
    drive(1, 5'd3, 1, 5'd2, 1, 5'd8, 1, 0, 0);
    chk("lu_pcw", 32'(pcWrite), 32'h0);
    chk("lu_ifidw", 32'(ifIdWrite), 32'h0);
    chk("lu_bubble", 32'(idExBubble), 32'h1);
    chk("lu_flush", 32'(ifIdFlush), 32'h0);
    step();
    chk("lu_stallcnt", 32'(stallCount), 32'h1);
    chk("lu_bubble_fs1", 32'(forwardSelect1), 32'h0);
    chk("lu_released", 32'(pcWrite), 32'h1);
    step();
    chk("lu_fs1", 32'(forwardSelect1), 32'h2);

    // lw x0 ; consumer of x0
    drive(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0); step();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0);
    chk("x0_nostall", 32'(pcWrite), 32'h1);
    step();
    chk("x0_fs1", 32'(forwardSelect1), 32'h0);

    // lw x4 ; instruction with rs2=4 but not reading rs2
    drive(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0); step();
    drive(1, 5'd1, 1, 5'd4, 0, 5'd9, 1, 0, 0);
    chk("unused_nostall", 32'(pcWrite), 32'h1);
    step();
    chk("unused_fs2", 32'(forwardSelect2), 32'h0);
    chk("unused_stallcnt", 32'(stallCount), 32'h1);

    // Flush beats stall: lw x9 ; add rs1=9 with taken branch in EX
    drive(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 0); step();
    drive(1, 5'd9, 1, 5'd9, 1, 5'd12, 1, 0, 1);
    chk("fl_ififlush", 32'(ifIdFlush), 32'h1);
    chk("fl_bubble", 32'(idExBubble), 32'h1);
    chk("fl_pcw", 32'(pcWrite), 32'h1);
    step();
    chk("fl_stallcnt", 32'(stallCount), 32'h1);
    chk("fl_flushcnt", 32'(flushCount), 32'h1);
    chk("fl_fs1", 32'(forwardSelect1), 32'h0);
    chk("fl_fs2", 32'(forwardSelect2), 32'h0);

    // Saturation: 300 more stalls on an 8-bit counter must stick at FF
    for (int i = 0; i < 300; i++) begin
      drive(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); step();
      drive(1, 5'd3, 1, 5'd0, 0, 5'd8, 1, 0, 0); step();
    end
    chk("sat_stallcnt", 32'(stallCount), 32'hFF);

    // Async reset in the middle of a stall
    drive(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); step();
    drive(1, 5'd3, 1, 5'd0, 0, 5'd8, 1, 0, 0);
    chk("rs_prestall", 32'(pcWrite), 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rs_pcw", 32'(pcWrite), 32'h1);
    chk("rs_ifidw", 32'(ifIdWrite), 32'h1);
    chk("rs_bubble", 32'(idExBubble), 32'h0);
    chk("rs_stallcnt", 32'(stallCount), 32'h0);
    chk("rs_flushcnt", 32'(flushCount), 32'h0);
    chk("rs_fs1", 32'(forwardSelect1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
